// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32IM pipeline front end.
//   RV32I_NOP       - canonical NOP (addi x0, x0, 0) used for pipeline bubbles
//   RV32I_RESET_PC  - default PC after reset
//   if_id_t         - IF/ID pipeline register contents
//   IF_ID_RESET     - IF/ID contents after reset
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV32I_NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] RV32I_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [ILEN-1:0] inst;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0004,
    inst:     RV32I_NOP,
    valid:    1'b0
  };

endpackage : rv32i_pkg

// File: rtl/rv32i_pc_reg.sv
// rv32i_pc_reg: program counter with next-PC selection.
//   clk, rst      - clock, asynchronous active-low reset
//   stall         - hold the PC
//   redirect      - load the word-aligned target (wins over stall)
//   target        - redirect target, low two bits are dropped
//   pc            - current PC
//   misaligned    - one-cycle pulse after a redirect whose target had [1:0] != 0
module rv32i_pc_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;

  always_comb begin
    pc_d  = pc_q + WIDTH'(4);  // natural wrap at 2^WIDTH
    mis_d = 1'b0;
    if (redirect) begin
      pc_d  = {target[WIDTH-1:2], 2'b00};
      mis_d = |target[1:0];
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = mis_q;

endmodule : rv32i_pc_reg

// File: rtl/rv32i_fetch_stage.sv
// rv32i_fetch_stage: IF stage of the RV32IM 5-stage pipeline.
//   clk, rst           - clock, asynchronous active-low reset
//   i_stall            - hold PC and IF/ID (load-use hazard)
//   i_flush            - replace IF/ID with a bubble
//   i_redirect         - taken branch/jump from EX
//   i_redirect_pc      - redirect target
//   o_imem_addr        - instruction memory address (the PC register)
//   i_imem_inst        - combinational read data for o_imem_addr
//   o_id_pc/_pc_plus4  - PC (and PC+4) of the instruction in IF/ID
//   o_id_inst          - instruction in IF/ID
//   o_id_valid         - IF/ID holds a real instruction
//   o_misaligned       - pulse: last redirect target was not word aligned
//   o_fetch_cnt        - number of instructions delivered to ID
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter int               WIDTH      = XLEN,
  parameter int               INST_WIDTH = ILEN,
  parameter logic [WIDTH-1:0] RESET_PC   = RV32I_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_redirect,
  input  logic [WIDTH-1:0]      i_redirect_pc,
  output logic [WIDTH-1:0]      o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  output logic [WIDTH-1:0]      o_id_pc,
  output logic [WIDTH-1:0]      o_id_pc_plus4,
  output logic [INST_WIDTH-1:0] o_id_inst,
  output logic                  o_id_valid,
  output logic                  o_misaligned,
  output logic [31:0]           o_fetch_cnt
);

  logic [WIDTH-1:0] pc;
  if_id_t           if_id_q, if_id_d;
  logic [31:0]      cnt_q, cnt_d;

  rv32i_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (i_stall),
    .redirect   (i_redirect),
    .target     (i_redirect_pc),
    .pc         (pc),
    .misaligned (o_misaligned)
  );

  // A bubble keeps the previous PC fields so downstream debug views stay stable;
  // only valid and the instruction word change. Redirect implies a bubble since
  // the word being fetched this cycle is on the wrong path.
  always_comb begin
    if_id_d = if_id_q;
    cnt_d   = cnt_q;
    if (i_redirect || i_flush) begin
      if_id_d.valid = 1'b0;
      if_id_d.inst  = RV32I_NOP;
    end else if (!i_stall) begin
      if_id_d.pc       = pc;
      if_id_d.pc_plus4 = pc + WIDTH'(4);
      if_id_d.inst     = i_imem_inst;
      if_id_d.valid    = 1'b1;
      cnt_d            = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_q <= IF_ID_RESET;
      cnt_q   <= 32'd0;
    end else begin
      if_id_q <= if_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_imem_addr   = pc;
  assign o_id_pc       = if_id_q.pc;
  assign o_id_pc_plus4 = if_id_q.pc_plus4;
  assign o_id_inst     = if_id_q.inst;
  assign o_id_valid    = if_id_q.valid;
  assign o_fetch_cnt   = cnt_q;

endmodule : rv32i_fetch_stage

// File: tb/tb_rv32i_fetch_stage.sv
module tb_rv32i_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall, i_flush, i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_addr, i_imem_inst;
  logic [31:0] o_id_pc, o_id_pc_plus4, o_id_inst;
  logic        o_id_valid, o_misaligned;
  logic [31:0] o_fetch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_addr   (o_imem_addr),
    .i_imem_inst   (i_imem_inst),
    .o_id_pc       (o_id_pc),
    .o_id_pc_plus4 (o_id_pc_plus4),
    .o_id_inst     (o_id_inst),
    .o_id_valid    (o_id_valid),
    .o_misaligned  (o_misaligned),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  // Instruction memory model: two real words at 0 and 4, address-tagged words elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return 32'h1000_0000 | a;
  endfunction

  assign i_imem_inst = imem(o_imem_addr);

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] inst;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic [31:0] inst, input logic valid,
                           input logic mis, input logic [31:0] cnt);
    check({tag, ".addr"},  o_imem_addr,   addr);
    check({tag, ".id_pc"}, o_id_pc,       pc);
    check({tag, ".pc4"},   o_id_pc_plus4, pc4);
    check({tag, ".inst"},  o_id_inst,     inst);
    check({tag, ".valid"}, {31'd0, o_id_valid},   {31'd0, valid});
    check({tag, ".mis"},   {31'd0, o_misaligned}, {31'd0, mis});
    check({tag, ".cnt"},   o_fetch_cnt,   cnt);
    $display("%s addr=%08h id_pc=%08h inst=%08h valid=%0b mis=%0b cnt=%0d",
             tag, o_imem_addr, o_id_pc, o_id_inst, o_id_valid, o_misaligned, o_fetch_cnt);
  endtask

  initial begin
    //          stall flush redir rpc           addr          id_pc         id_pc4        inst          v     mis   cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h0050_0093, 1'b1, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h00A0_0113, 1'b1, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h00A0_0113, 1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h00A0_0113, 1'b1, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        32'h1000_0008, 1'b1, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'hC,        32'h10,       32'h1000_000C, 1'b1, 1'b0, 32'd4};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h40,       32'h40,       32'hC,        32'h10,       32'h0000_0013, 1'b0, 1'b0, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       32'h1000_0040, 1'b1, 1'b0, 32'd5};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h46,       32'h44,       32'h40,       32'h44,       32'h0000_0013, 1'b0, 1'b1, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'h44,       32'h48,       32'h1000_0044, 1'b1, 1'b0, 32'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h20,       32'h20,       32'h44,       32'h48,       32'h0000_0013, 1'b0, 1'b0, 32'd6};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h24,       32'h44,       32'h48,       32'h0000_0013, 1'b0, 1'b0, 32'd6};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h28,       32'h24,       32'h28,       32'h1000_0024, 1'b1, 1'b0, 32'd7};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h28,       32'h24,       32'h28,       32'h0000_0013, 1'b0, 1'b0, 32'd7};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h24,      32'h28,       32'h0000_0013, 1'b0, 1'b0, 32'd7};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 32'd8};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h0050_0093, 1'b1, 1'b0, 32'd9};

    rst = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;

    // Held in reset for three edges: outputs must sit at reset values.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      i_stall       = vecs[i].stall;
      i_flush       = vecs[i].flush;
      i_redirect    = vecs[i].redirect;
      i_redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].id_pc, vecs[i].id_pc4,
                vecs[i].inst, vecs[i].valid, vecs[i].mis, vecs[i].cnt);
      @(negedge clk);
    end

    // Asynchronous reset between edges, with stall and redirect active.
    i_stall       = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h80;
    #1;
    rst = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0, 32'd0);

    // First edge after release captures the word at the reset PC.
    @(negedge clk);
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_release", 32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule : tb_rv32i_fetch_stage
